// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
//   uart_tx_st_t : transmit FSM state encoding
//   UART_DATA_BITS / UART_FRAME_BITS : data bits per frame / start+data+stop
//   uart_div()   : rounded clock divisor for a given clock and baud rate
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_tx_st_t;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;

   // Round to nearest so the bit period error is at most half a clock.
   function automatic int uart_div(input longint clk_hz, input longint baud);
      return int'((clk_hz + (baud / 64'sd2)) / baud);
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a producer (master) and the UART transmitter (slave).
//   tx_data  : byte to send
//   tx_valid : tx_data valid
//   tx_ready : transmitter can accept; transfer on an edge with valid && ready
interface uart_tx_ctrl_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with separately tracked occupancy.
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : write request/data (ignored when full, even with a pop)
//   pop, rdata   : read request; rdata is the head entry, combinational
//   full, empty  : occupancy flags decoded from the registered level
//   level        : entries held, 0..D
module uart_sync_fifo #(
   parameter int W = 8,
   parameter int D = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [W-1:0]         wdata,
   input  logic                 pop,
   output logic [W-1:0]         rdata,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(D):0]   level
);
   localparam int AW = $clog2(D);
   localparam int LW = AW + 1;

   if ((D < 2) || ((D & (D - 1)) != 0)) begin : g_bad_depth
      $error("uart_sync_fifo: D must be a power of 2 and >= 2");
   end

   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok_s, pop_ok_s;

   assign full  = (level_q == LW'(D));
   assign empty = (level_q == {LW{1'b0}});
   assign level = level_q;
   assign rdata = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at D.
   always_comb begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
         2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
         default: level_d = level_q;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter with input byte FIFO, LSB first, fixed baud rate.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   bus (slave)        : tx_data/tx_valid/tx_ready byte handshake
//   txd                : serial line, registered, idle high
//   busy               : frame in progress or bytes queued
//   fifo_level         : FIFO occupancy, 0..P_FIFO_DEPTH
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int P_CLK_HZ     = 50_000_000,
   parameter int P_BAUD       = 115_200,
   parameter int P_FIFO_DEPTH = 16
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   uart_tx_ctrl_if.slave                 bus,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(P_FIFO_DEPTH):0] fifo_level
);
   localparam int P_DIV = uart_div(64'(P_CLK_HZ), 64'(P_BAUD));
   localparam int BW    = (P_DIV < 2) ? 1 : $clog2(P_DIV);
   localparam logic [BW-1:0] DIV_LAST = BW'(P_DIV - 1);
   localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

   if (P_DIV < 2) begin : g_bad_div
      $error("uart_tx_ctrl: clock divisor must be at least 2");
   end

   uart_tx_st_t               state_q, state_d;
   logic [BW-1:0]             baud_cnt_q, baud_cnt_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      txd_q, txd_d;
   logic                      busy_q, busy_d;
   logic                      pop_s, full_s, empty_s, baud_last_s;
   logic [UART_DATA_BITS-1:0] rd_data_s;

   uart_sync_fifo #(.W(UART_DATA_BITS), .D(P_FIFO_DEPTH)) u_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (bus.tx_valid),
      .wdata (bus.tx_data),
      .pop   (pop_s),
      .rdata (rd_data_s),
      .full  (full_s),
      .empty (empty_s),
      .level (fifo_level)
   );

   assign bus.tx_ready = !full_s;
   assign txd          = txd_q;
   assign busy         = busy_q;
   assign baud_last_s  = (baud_cnt_q == DIV_LAST);

   // FSM next-state; a pop loads shift_q on the same edge because the FIFO head is combinational.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pop_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = {BW{1'b0}};
            bit_cnt_d  = 3'd0;
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = rd_data_s;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_last_s) begin
               baud_cnt_d = {BW{1'b0}};
               bit_cnt_d  = 3'd0;
               state_d    = ST_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            end
         end
         ST_DATA: begin
            if (baud_last_s) begin
               baud_cnt_d = {BW{1'b0}};
               shift_d    = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            end
         end
         ST_STOP: begin
            if (baud_last_s) begin
               baud_cnt_d = {BW{1'b0}};
               // Chain straight into the next frame so there is no idle gap.
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  shift_d = rd_data_s;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d    = ST_IDLE;
            baud_cnt_d = {BW{1'b0}};
            bit_cnt_d  = 3'd0;
         end
      endcase
   end

   // Line and busy are decoded from the current state and registered, so both trail the FSM by one cycle.
   always_comb begin
      case (state_q)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_q[0];
         default:  txd_d = 1'b1;
      endcase
      busy_d = (state_q != ST_IDLE) || (fifo_level != '0);
   end

   // State and datapath registers.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= {BW{1'b0}};
         bit_cnt_q  <= 3'd0;
         shift_q    <= {UART_DATA_BITS{1'b0}};
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       txd, busy;
   logic [2:0] fifo_level;
   int         cyc = 0;
   int         n_pass = 0;
   int         n_total = 0;

   // Receive-side model state.
   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic       rx_stop[$];

   // Stimulus bookkeeping.
   logic [7:0] tx_q[$];
   int         acc_q[$];
   int         lvl_at[int];
   int         rdy_at[int];

   uart_tx_ctrl_if bus ();

   uart_tx_ctrl #(
      .P_CLK_HZ     (1_000_000),
      .P_BAUD       (100_000),
      .P_FIFO_DEPTH (4)
   ) dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .bus        (bus.slave),
      .txd        (txd),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line receiver: samples mid-bit at 10 clocks per bit.
   initial begin
      logic [7:0] b;
      int st;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txd === 1'b0) begin
            st = cyc;
            repeat (5) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (10) @(negedge clk);
               b[i] = txd;
            end
            repeat (10) @(negedge clk);
            rx_q.push_back(b);
            rx_t.push_back(st);
            rx_stop.push_back(txd);
         end
      end
   end

   task automatic flush_rx();
      rx_q.delete();
      rx_t.delete();
      rx_stop.delete();
   endtask

   // Present tx_q with tx_valid held; logs accept edges and level/ready per cycle.
   task automatic drive_queue(output bit timed_out);
      int guard = 0;
      timed_out = 1'b0;
      acc_q.delete();
      lvl_at.delete();
      rdy_at.delete();
      while (tx_q.size() > 0 && guard < 2000) begin
         @(negedge clk);
         lvl_at[cyc] = int'(fifo_level);
         rdy_at[cyc] = int'(bus.tx_ready);
         bus.tx_valid = 1'b1;
         bus.tx_data  = tx_q[0];
         if (bus.tx_ready === 1'b1) begin
            acc_q.push_back(cyc + 1);
            void'(tx_q.pop_front());
         end
         guard++;
      end
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (guard >= 2000) timed_out = 1'b1;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic wait_idle(output bit ok);
      int c = 0;
      while (busy !== 1'b0 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      repeat (20) @(negedge clk);
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      int bad = 0;
      rst_n = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_total++;
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || bus.tx_ready !== 1'b1)
         $display("FAIL reset_state txd=%b busy=%b level=%0d ready=%b, need 1 0 0 1",
                  txd, busy, fifo_level, bus.tx_ready);
      else n_pass++;
      rst_n = 1'b1;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || bus.tx_ready !== 1'b1) bad++;
      end
      n_total++;
      if (bad != 0)
         $display("FAIL reset_idle %0d of 200 cycles not idle (txd=%b busy=%b level=%0d ready=%b)",
                  bad, txd, busy, fifo_level, bus.tx_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [7:0] e = 8'hA5;
      logic exp_txd, exp_busy;
      int k, bad_txd = 0, bad_busy = 0;
      bit ok;
      flush_rx();
      @(negedge clk);
      bus.tx_data  = e;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      k = cyc + 1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      n_total++;
      if (fifo_level !== 3'd1) $display("FAIL single_level_push level=%0d need 1", fifo_level);
      else n_pass++;
      for (int j = 1; j <= 105; j++) begin
         @(negedge clk);
         if (j == 1) begin
            n_total++;
            if (fifo_level !== 3'd0) $display("FAIL single_level_pop level=%0d need 0", fifo_level);
            else n_pass++;
         end
         if (j >= 2 && j <= 11)       exp_txd = 1'b0;
         else if (j >= 12 && j <= 91) exp_txd = e[(j - 12) / 10];
         else                         exp_txd = 1'b1;
         exp_busy = (j <= 101);
         if (txd !== exp_txd) begin
            bad_txd++;
            $display("FAIL single_txd at k+%0d txd=%b need %b", j, txd, exp_txd);
         end
         if (busy !== exp_busy) begin
            bad_busy++;
            $display("FAIL single_busy at k+%0d busy=%b need %b", j, busy, exp_busy);
         end
      end
      n_total++;
      if (bad_txd == 0) n_pass++;
      n_total++;
      if (bad_busy == 0) n_pass++;
      wait_rx(1, 50, ok);
      n_total++;
      if (!ok || rx_q[0] !== 8'hA5 || rx_t[0] != k + 2)
         $display("FAIL single_rx got %0d bytes first=%h start=%0d, need A5 at %0d",
                  rx_q.size(), ok ? rx_q[0] : 8'hxx, ok ? rx_t[0] : -1, k + 2);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3] = '{8'h00, 8'hFF, 8'h55};
      bit to, ok;
      flush_rx();
      tx_q = '{8'h00, 8'hFF, 8'h55};
      drive_queue(to);
      n_total++;
      if (to) $display("FAIL burst_accept timeout, %0d bytes left, need 0", tx_q.size());
      else n_pass++;
      wait_rx(3, 600, ok);
      n_total++;
      if (!ok) $display("FAIL burst_rx_count got %0d frames need 3", rx_q.size());
      else n_pass++;
      if (ok) begin
         for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rx_q[i] !== exp_b[i] || rx_stop[i] !== 1'b1)
               $display("FAIL burst_byte%0d got %h stop=%b need %h stop=1",
                        i, rx_q[i], rx_stop[i], exp_b[i]);
            else n_pass++;
         end
         n_total++;
         if (rx_t[0] != acc_q[0] + 2)
            $display("FAIL burst_first_start got %0d need %0d", rx_t[0], acc_q[0] + 2);
         else n_pass++;
         n_total++;
         if (rx_t[1] - rx_t[0] != 100 || rx_t[2] - rx_t[1] != 100)
            $display("FAIL burst_spacing got %0d,%0d need 100,100",
                     rx_t[1] - rx_t[0], rx_t[2] - rx_t[1]);
         else n_pass++;
      end
      wait_idle(ok);
   endtask

   task automatic test_fifo_full();
      int exp_off [6] = '{0, 1, 2, 3, 4, 102};
      logic [7:0] exp_b [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      int e0;
      bit to, ok;
      flush_rx();
      tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      drive_queue(to);
      n_total++;
      if (to || acc_q.size() != 6) $display("FAIL full_accept accepted %0d need 6", acc_q.size());
      else n_pass++;
      if (acc_q.size() == 6) begin
         e0 = acc_q[0];
         n_total++;
         if (acc_q[1] - e0 != exp_off[1] || acc_q[2] - e0 != exp_off[2] ||
             acc_q[3] - e0 != exp_off[3] || acc_q[4] - e0 != exp_off[4] ||
             acc_q[5] - e0 != exp_off[5])
            $display("FAIL full_accept_edges got +%0d,+%0d,+%0d,+%0d,+%0d need +1,+2,+3,+4,+102",
                     acc_q[1] - e0, acc_q[2] - e0, acc_q[3] - e0, acc_q[4] - e0, acc_q[5] - e0);
         else n_pass++;
         n_total++;
         if (!lvl_at.exists(e0 + 4) || lvl_at[e0 + 4] != 4 || rdy_at[e0 + 4] != 0)
            $display("FAIL full_ready_drop at e0+4 level=%0d ready=%0d need 4 0",
                     lvl_at.exists(e0 + 4) ? lvl_at[e0 + 4] : -1,
                     rdy_at.exists(e0 + 4) ? rdy_at[e0 + 4] : -1);
         else n_pass++;
         n_total++;
         if (!lvl_at.exists(e0 + 101) || lvl_at[e0 + 101] != 3)
            $display("FAIL full_push_pop_reject level after pop edge=%0d need 3",
                     lvl_at.exists(e0 + 101) ? lvl_at[e0 + 101] : -1);
         else n_pass++;
      end
      wait_rx(6, 800, ok);
      n_total++;
      if (!ok || rx_q.size() != 6) $display("FAIL full_rx_count got %0d frames need 6", rx_q.size());
      else n_pass++;
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_total++;
            if (rx_q[i] !== exp_b[i] || rx_stop[i] !== 1'b1)
               $display("FAIL full_byte%0d got %h stop=%b need %h stop=1",
                        i, rx_q[i], rx_stop[i], exp_b[i]);
            else n_pass++;
         end
      end
      wait_idle(ok);
   endtask

   task automatic test_reset_midframe();
      int e0, guard = 0, bad = 0;
      bit to, ok;
      flush_rx();
      tx_q = '{8'h3C, 8'h7E, 8'h99};
      drive_queue(to);
      n_total++;
      if (to || acc_q.size() != 3) $display("FAIL rst_setup accepted %0d need 3", acc_q.size());
      else n_pass++;
      e0 = (acc_q.size() > 0) ? acc_q[0] : cyc;
      while (cyc < e0 + 45 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_total++;
      if (fifo_level !== 3'd2) $display("FAIL rst_queued level=%0d need 2", fifo_level);
      else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_total++;
      if (txd !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0 || bus.tx_ready !== 1'b1)
         $display("FAIL rst_midframe txd=%b level=%0d busy=%b ready=%b need 1 0 0 1",
                  txd, fifo_level, busy, bus.tx_ready);
      else n_pass++;
      for (int j = 0; j < 300; j++) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL rst_no_more_frames %0d active cycles need 0", bad);
      else n_pass++;
      flush_rx();
      tx_q = '{8'h81};
      drive_queue(to);
      wait_rx(1, 200, ok);
      n_total++;
      if (!ok || rx_q[0] !== 8'h81 || rx_stop[0] !== 1'b1 || rx_t[0] != acc_q[0] + 2)
         $display("FAIL rst_after_byte got %0d frames byte=%h need 81 at %0d",
                  rx_q.size(), ok ? rx_q[0] : 8'hxx, acc_q.size() > 0 ? acc_q[0] + 2 : -1);
      else n_pass++;
      wait_idle(ok);
      n_total++;
      if (!ok || rx_q.size() != 1) $display("FAIL rst_final_idle busy=%b frames=%0d need 0 1", busy, rx_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
